// File: rtl/des_round_engine_if.sv
// Request/result bundle between a DES round engine and its controller.
interface des_round_engine_if;
   logic        start;
   logic        decrypt;
   logic [63:0] key_in;
   logic [63:0] data_in;
   logic        busy;
   logic        done;
   logic [63:0] data_out;

   modport master (output start, decrypt, key_in, data_in, input busy, done, data_out);
   modport slave  (input start, decrypt, key_in, data_in, output busy, done, data_out);
endinterface

// File: rtl/des_round_engine.sv
// Iterative DES engine: one Feistel round per clock, encrypt or decrypt.
// Holds the key schedule and the round function Eff internally.
//
// state | meaning
// IDLE  | waiting for start; all datapath state held
// ROUND | executing round 1..16
// OUT   | final swap + FP into data_out, pulse done
module des_round_engine (
   input  logic              clk,
   input  logic              rst_n,
   des_round_engine_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ROUND, OUT} state_t;

   // Tables hold 1-based DES bit numbers, DES bit 1 being the MSB.
   localparam int IP_T [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
   localparam int FP_T [64] = '{
      40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
   localparam int PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
   localparam int PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
   localparam int E_T [48] = '{
      32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
   localparam int P_T [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
   // Each S-box is 64 nibbles indexed {row, col}, entry 0 in the top nibble.
   localparam logic [255:0] SBOX [8] = '{
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
      256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

   function automatic logic [63:0] perm_ip(input logic [63:0] x);
      logic [63:0] y;
      for (int k = 0; k < 64; k++) y[63-k] = x[64-IP_T[k]];
      return y;
   endfunction

   function automatic logic [63:0] perm_fp(input logic [63:0] x);
      logic [63:0] y;
      for (int k = 0; k < 64; k++) y[63-k] = x[64-FP_T[k]];
      return y;
   endfunction

   function automatic logic [55:0] perm_pc1(input logic [63:0] x);
      logic [55:0] y;
      for (int k = 0; k < 56; k++) y[55-k] = x[64-PC1_T[k]];
      return y;
   endfunction

   function automatic logic [47:0] perm_pc2(input logic [55:0] x);
      logic [47:0] y;
      for (int k = 0; k < 48; k++) y[47-k] = x[56-PC2_T[k]];
      return y;
   endfunction

   function automatic logic [31:0] eff(input logic [31:0] f_reg_in, input logic [47:0] key);
      logic [47:0] x;
      logic [31:0] s;
      logic [31:0] y;
      logic [5:0]  six;
      int          idx;
      for (int k = 0; k < 48; k++) x[47-k] = f_reg_in[32-E_T[k]];
      x = x ^ key;
      for (int b = 0; b < 8; b++) begin
         six = x[47-6*b -: 6];
         idx = {26'd0, six[5], six[0], six[4:1]};
         s[31-4*b -: 4] = SBOX[b][255-4*idx -: 4];
      end
      for (int k = 0; k < 32; k++) y[31-k] = s[32-P_T[k]];
      return y;
   endfunction

   function automatic logic [1:0] shift_amt(input logic [4:0] i);
      return (i == 5'd1 || i == 5'd2 || i == 5'd9 || i == 5'd16) ? 2'd1 : 2'd2;
   endfunction

   function automatic logic [27:0] rotl28(input logic [27:0] v, input logic [1:0] sh);
      return (sh == 2'd1) ? {v[26:0], v[27]} : {v[25:0], v[27:26]};
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] v, input logic [1:0] sh);
      return (sh == 2'd1) ? {v[0], v[27:1]} : {v[1:0], v[27:2]};
   endfunction

   state_t      state;
   logic [31:0] l_half, r_half;
   logic [27:0] c_half, d_half;
   logic [4:0]  round;
   logic        mode;

   logic [1:0]  sh;
   logic [27:0] c_next, d_next;
   logic [47:0] subkey;
   logic [31:0] f_out;

   // Decrypt reads the schedule backwards: use the unshifted key, then undo this round's shift.
   always_comb begin
      sh = shift_amt(mode ? 5'd17 - round : round);
      c_next = rotl28(c_half, sh);
      d_next = rotl28(d_half, sh);
      subkey = perm_pc2({c_next, d_next});
      if (mode) begin
         c_next = rotr28(c_half, sh);
         d_next = rotr28(d_half, sh);
         subkey = perm_pc2({c_half, d_half});
      end
      f_out = eff(r_half, subkey);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         l_half       <= '0;
         r_half       <= '0;
         c_half       <= '0;
         d_half       <= '0;
         round        <= '0;
         mode         <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.data_out <= '0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  {l_half, r_half} <= perm_ip(bus.data_in);
                  {c_half, d_half} <= perm_pc1(bus.key_in);
                  mode     <= bus.decrypt;
                  round    <= 5'd1;
                  bus.busy <= 1'b1;
                  state    <= ROUND;
               end
            end
            ROUND: begin
               if (round == 5'd0 || round > 5'd16) begin
                  bus.busy <= 1'b0;
                  state    <= IDLE;
               end else begin
                  l_half <= r_half;
                  r_half <= l_half ^ f_out;
                  c_half <= c_next;
                  d_half <= d_next;
                  if (round == 5'd16) state <= OUT;
                  else                round <= round + 5'd1;
               end
            end
            OUT: begin
               bus.data_out <= perm_fp({r_half, l_half});
               bus.done     <= 1'b1;
               bus.busy     <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_des_round_engine.sv
// Directed bench for des_round_engine using known DES vectors.
module tb_des_round_engine;
   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   des_round_engine_if bus ();

   des_round_engine dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
   localparam logic [63:0] PT_A   = 64'h0123456789ABCDEF;
   localparam logic [63:0] CT_A   = 64'h85E813540F0AB405;
   localparam logic [63:0] CT_Z   = 64'h8CA64DE9C1B123A7;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [63:0] key, input logic [63:0] data, input logic dec);
      @(negedge clk);
      bus.key_in  = key;
      bus.data_in = data;
      bus.decrypt = dec;
      bus.start   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Counts edges after E0 until done is seen; bounded at 40.
   task automatic wait_done(input int lat0, input bit churn, input int pulse_at, output int lat);
      lat = lat0;
      while (lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (bus.done) break;
         if (churn) begin
            bus.key_in  = {$urandom, $urandom};
            bus.data_in = {$urandom, $urandom};
            bus.decrypt = 1'($urandom);
         end
         if (lat == pulse_at - 1) begin
            bus.start   = 1'b1;
            bus.data_in = 64'hFFFF_FFFF_FFFF_FFFF;
         end else begin
            bus.start = 1'b0;
         end
      end
   endtask

   task automatic finish_op(input string tag, input int lat, input logic [63:0] exp);
      chk({tag, " latency"}, 64'(lat), 64'd17);
      chk({tag, " data_out"}, bus.data_out, exp);
      chk({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
      @(negedge clk);
      chk({tag, " done_width"}, 64'(bus.done), 64'd0);
      chk({tag, " data_hold"}, bus.data_out, exp);
   endtask

   initial begin
      int lat;
      int acc [4];
      int n_acc, n_done, wide, seen;
      logic prev_busy, prev_done;

      bus.start   = 1'b0;
      bus.decrypt = 1'b0;
      bus.key_in  = '0;
      bus.data_in = '0;

      #2 rst_n = 1'b0;
      #1;
      chk("reset busy", 64'(bus.busy), 64'd0);
      chk("reset done", 64'(bus.done), 64'd0);
      chk("reset data_out", bus.data_out, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Encrypt reference vector, with first-round internals
      start_op(KEY_A, PT_A, 1'b0);
      chk("enc busy_after_e0", 64'(bus.busy), 64'd1);
      @(posedge clk);
      @(negedge clk);
      chk("enc L_after_e1", 64'(dut.l_half), 64'hF0AAF0AA);
      chk("enc R_after_e1", 64'(dut.r_half), 64'hEF4A6544);
      wait_done(1, 1'b0, 0, lat);
      finish_op("enc", lat, CT_A);

      start_op(KEY_A, CT_A, 1'b1);
      wait_done(0, 1'b0, 0, lat);
      finish_op("dec", lat, PT_A);

      // Parity bits must not matter
      start_op(64'h0, 64'h0, 1'b0);
      wait_done(0, 1'b0, 0, lat);
      finish_op("zero_key", lat, CT_Z);
      start_op(64'h0101010101010101, 64'h0, 1'b0);
      wait_done(0, 1'b0, 0, lat);
      finish_op("parity_key", lat, CT_Z);

      // Stray start at E5 with other data must be ignored
      start_op(KEY_A, PT_A, 1'b0);
      wait_done(0, 1'b0, 5, lat);
      finish_op("start_while_busy", lat, CT_A);

      // Reset during round 8
      start_op(KEY_A, PT_A, 1'b0);
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst busy", 64'(bus.busy), 64'd0);
      chk("midrst done", 64'(bus.done), 64'd0);
      chk("midrst data_out", bus.data_out, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (bus.done || bus.busy) seen = 1;
      end
      chk("midrst no_activity", 64'(seen), 64'd0);
      start_op(KEY_A, PT_A, 1'b0);
      wait_done(0, 1'b0, 0, lat);
      finish_op("after_rst", lat, CT_A);

      // start held high: accepts every 18 cycles
      @(negedge clk);
      bus.key_in  = '0;
      bus.data_in = '0;
      bus.decrypt = 1'b0;
      bus.start   = 1'b1;
      prev_busy = 1'b0;
      prev_done = 1'b0;
      n_acc = 0;
      n_done = 0;
      wide = 0;
      for (int i = 0; i < 4; i++) acc[i] = -1;
      for (int i = 0; i < 54; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.busy && !prev_busy) begin
            if (n_acc < 4) acc[n_acc] = i;
            n_acc++;
         end
         if (bus.done) begin
            n_done++;
            if (prev_done) wide++;
         end
         prev_busy = bus.busy;
         prev_done = bus.done;
      end
      bus.start = 1'b0;
      chk("b2b accepts", 64'(n_acc), 64'd3);
      chk("b2b first", 64'(acc[0]), 64'd0);
      chk("b2b second", 64'(acc[1]), 64'd18);
      chk("b2b third", 64'(acc[2]), 64'd36);
      chk("b2b dones", 64'(n_done), 64'd3);
      chk("b2b done_wide", 64'(wide), 64'd0);
      chk("b2b data_out", bus.data_out, CT_Z);

      // Input churn after E0
      start_op(KEY_A, PT_A, 1'b0);
      wait_done(0, 1'b1, 0, lat);
      finish_op("churn_enc", lat, CT_A);
      start_op(64'h0, CT_Z, 1'b1);
      wait_done(0, 1'b1, 0, lat);
      finish_op("churn_dec", lat, 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/des_round_engine.md
# des_round_engine

Iterative 16-round DES datapath that feeds the `Eff` round function and consumes its output. It is the stage directly upstream and downstream of `Eff`. It does the following:
- applies IP to a 64-bit block;
- generates each round subkey from the 64-bit key (PC-1, rotations, PC-2);
- drives `Eff` with R and the subkey, and folds the result into L;
- swaps the halves after round 16 and applies FP.

It processes one round per clock and handles both encrypt and decrypt.

## Interface
Parameters: none. All widths are fixed by DES. Bit numbering: DES bit 1 is the MSB, [63] or [47] or [31].
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `start` in 1: request a new operation. Sampled only in IDLE.
- `decrypt` in 1: 0 = encrypt, 1 = decrypt. Sampled with `start`.
- `key_in` in 64: DES key including parity bits. Parity bits are ignored (dropped by PC-1).
- `data_in` in 64: plaintext or ciphertext block.
- `busy` out 1: high while an operation is in progress.
- `done` out 1: one-cycle pulse; `data_out` is valid.
- `data_out` out 64: result block. Holds its value until the next `done` or reset.

## Operation
- Internal state:
  - L, R (32 bits each);
  - C, D (28 bits each);
  - round counter (5 bits, values 1..16);
  - mode bit;
  - FSM with states IDLE, ROUND, OUT.
- IDLE, `start`=1 at edge E0:
  - {L,R} <= IP(data_in);
  - {C,D} <= PC1(key_in);
  - mode <= decrypt;
  - round <= 1;
  - go to ROUND; `busy` becomes 1.
- IDLE, `start`=0: hold all state.
- ROUND, round i, at edge Ei:
  - Shift schedule s = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Encrypt:
    - C' = rotl(C, s[i]), D' = rotl(D, s[i]);
    - K = PC2(C',D');
    - C,D <= C',D'.
  - Decrypt:
    - K = PC2(C,D), i.e. unshifted; this yields K16 at i=1;
    - C,D <= rotr(C, s[17-i]), rotr(D, s[17-i]).
  - `Eff` receives f_reg_in = R and key = K. Its output is combinational.
  - L <= R; R <= L ^ f_out.
  - round <= i+1. At i=16, go to OUT instead.
- OUT, at E17:
  - data_out <= FP({R,L}), i.e. with the final swap;
  - `done` <= 1 for one cycle;
  - `busy` <= 0;
  - go to IDLE.
- Total rotation over 16 rounds is 28. C and D therefore return to their PC-1 values at the end, in both modes.
- `key_in`, `data_in` and `decrypt` are ignored after E0. Changing them mid-operation has no effect.
- `start` while `busy`=1 is ignored. It is not queued.
- Round counter never wraps. Values 0 and 17..31 are unreachable; if reached, the FSM returns to IDLE.

## Timing
- Reset values (async, immediate):
  - `busy`=0, `done`=0, `data_out`=0;
  - L, R, C, D, round = 0;
  - FSM = IDLE.
- Reset asserted mid-operation aborts the operation. No `done` pulse follows; the first `start` after reset release begins a fresh operation.
- Latency: `start` sampled at E0, then `done` is high in the cycle after E17, i.e. 17 clocks.
- `busy`: high after E0 through E17, low after E17.
- `done`: high exactly one cycle, deasserted at E18.
- Back-to-back: `start` held high continuously gives accepts at E0, E18, E36, and so on. Throughput is 18 cycles per block.
- `start` high in the same cycle as `done`: sampled at E18 and accepted, because the FSM is in IDLE.
- Critical path per cycle: PC2 + rotate + `Eff` (E, XOR, S-boxes, P) + XOR into R.

## Test plan
- Encrypt: key 133457799BBCDFF1, data 0123456789ABCDEF.
  - After E1: L = F0AAF0AA and R = EF4A6544 (K1 = 1B02EFFC7072).
  - `done` one cycle after E17, with data_out = 85E813540F0AB405.
- Decrypt: same key, data 85E813540F0AB405, decrypt=1 -> data_out = 0123456789ABCDEF, with the same latency.
- Parity ignored: key 0000000000000000 and key 0101010101010101, each with data 0000000000000000 -> both give 8CA64DE9C1B123A7.
- Handshake:
  - pulse `start` again at E5 with different data_in -> ignored; the result is unchanged.
  - hold `start` high -> accepts occur exactly 18 cycles apart.
  - `done` is never wider than one cycle.
- Reset mid-operation: assert `rst_n`=0 during round 8 -> `busy`, `done` and `data_out` go to 0 immediately; no `done` pulse follows. A new encrypt after release produces the correct result.
- Input churn: randomize `key_in`, `data_in` and `decrypt` every cycle after E0 -> the result matches the values sampled at E0.
